// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven time-setting controller for an H:M:S clock.
// Two raw buttons (mode, inc) are synchronized and debounced into one-cycle
// press events. Mode presses walk RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN;
// inc presses advance the captured field with wrap. Leaving a SET state
// produces a one-cycle load strobe for that field on the following cycle.
// Optional feature macro: CLOCK_SET_AUTOREPEAT_EN (hold-to-repeat on inc).
//
// Strobe semantics: loaden_hr/min/sec are one-cycle pulses, at most one high
// at a time, qualifying load; load is 0 whenever no strobe is high. There is
// no back-pressure; the counters must accept a load in the strobe cycle.
//
// Press timing: counting the first clk edge that samples a new raw level as
// edge 1, the internal press pulse is high after edge DEBOUNCE_CYCLES+3 and
// the FSM acts on it at the next edge.
module clock_set_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter logic [6:0] HR_MAX          = 7'd23,
    parameter logic [6:0] MIN_MAX         = 7'd59,
    parameter logic [6:0] SEC_MAX         = 7'd59,
    parameter int         REPEAT_DELAY    = 64,
    parameter int         REPEAT_RATE     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [6:0] cur_hr,
    input  logic [6:0] cur_min,
    input  logic [6:0] cur_sec,
    output logic [6:0] load,
    output logic       loaden_hr,
    output logic       loaden_min,
    output logic       loaden_sec,
    output logic       run_en,
    output logic [1:0] mode,
    output logic [6:0] edit_val
);

    localparam int              DCW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCW-1:0]  DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_t;

    // Button lanes: index 0 = mode, index 1 = inc.
    logic [1:0]     sync1, sync2, stable, stable_d, press_q;
    logic [DCW-1:0] db_cnt [2];

    state_t     state_q, state_d;
    logic [6:0] edit_q, edit_d;
    logic [6:0] load_q, load_d;
    logic [2:0] loaden_q, loaden_d;   // {sec, min, hr}
    logic       run_en_q, run_en_d;
    logic       mode_evt, inc_evt;

    // Seconds always restart from 0 on entry to SET_SEC, so cur_sec is never read.
    logic unused_cur_sec;
    assign unused_cur_sec = ^cur_sec;

    // Synchronize, debounce and edge-detect both buttons.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            press_q  <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1    <= {btn_inc, btn_mode};
            sync2    <= sync1;
            stable_d <= stable;
            press_q  <= stable & ~stable_d;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign mode_evt = press_q[0];

`ifdef CLOCK_SET_AUTOREPEAT_EN
    logic [15:0] rep_cnt;
    logic        rep_first;
    logic        rep_press_q;

    // While inc stays held in a SET state, emit extra presses after
    // REPEAT_DELAY cycles and then every REPEAT_RATE cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt     <= '0;
            rep_first   <= 1'b1;
            rep_press_q <= 1'b0;
        end else begin
            rep_press_q <= 1'b0;
            if (state_q == ST_RUN || !stable[1]) begin
                rep_cnt   <= '0;
                rep_first <= 1'b1;
            end else if (press_q[1]) begin
                rep_cnt   <= 16'd1;
                rep_first <= 1'b1;
            end else if (rep_cnt == (rep_first ? 16'(REPEAT_DELAY - 1)
                                                : 16'(REPEAT_RATE - 1))) begin
                rep_press_q <= 1'b1;
                rep_cnt     <= '0;
                rep_first   <= 1'b0;
            end else begin
                rep_cnt <= rep_cnt + 16'd1;
            end
        end
    end

    assign inc_evt = press_q[1] | rep_press_q;
`else
    assign inc_evt = press_q[1];
`endif

    // FSM and edit/strobe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            edit_q   <= '0;
            load_q   <= '0;
            loaden_q <= '0;
            run_en_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            edit_q   <= edit_d;
            load_q   <= load_d;
            loaden_q <= loaden_d;
            run_en_q <= run_en_d;
        end
    end

    // Next-state, edit update and exit-strobe generation; mode wins over inc.
    always_comb begin
        state_d  = state_q;
        edit_d   = edit_q;
        load_d   = '0;
        loaden_d = '0;
        run_en_d = run_en_q;
        if (loaden_q[2]) run_en_d = 1'b1;
        case (state_q)
            ST_RUN: begin
                if (mode_evt) begin
                    state_d  = ST_SET_HR;
                    edit_d   = cur_hr;
                    run_en_d = 1'b0;
                end
            end
            ST_SET_HR: begin
                if (mode_evt) begin
                    state_d  = ST_SET_MIN;
                    edit_d   = cur_min;
                    load_d   = edit_q;
                    loaden_d = 3'b001;
                end else if (inc_evt) begin
                    edit_d = (edit_q >= HR_MAX) ? 7'd0 : edit_q + 7'd1;
                end
            end
            ST_SET_MIN: begin
                if (mode_evt) begin
                    state_d  = ST_SET_SEC;
                    edit_d   = 7'd0;
                    load_d   = edit_q;
                    loaden_d = 3'b010;
                end else if (inc_evt) begin
                    edit_d = (edit_q >= MIN_MAX) ? 7'd0 : edit_q + 7'd1;
                end
            end
            ST_SET_SEC: begin
                if (mode_evt) begin
                    state_d  = ST_RUN;
                    edit_d   = 7'd0;
                    load_d   = edit_q;
                    loaden_d = 3'b100;
                end else if (inc_evt) begin
                    edit_d = (edit_q >= SEC_MAX) ? 7'd0 : edit_q + 7'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign mode       = state_q;
    assign edit_val   = edit_q;
    assign load       = load_q;
    assign loaden_hr  = loaden_q[0];
    assign loaden_min = loaden_q[1];
    assign loaden_sec = loaden_q[2];
    assign run_en     = run_en_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed vector table, debounce/reset corner sequences,
// hold/auto-repeat check and a randomized run against a behavioural model.
module tb_clock_set_ctrl;

    localparam int D = 16;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_inc;
    logic [6:0] cur_hr, cur_min, cur_sec;
    logic [6:0] load, edit_val;
    logic       loaden_hr, loaden_min, loaden_sec, run_en;
    logic [1:0] mode;

    always #5 clk = ~clk;

    clock_set_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .cur_hr     (cur_hr),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .load       (load),
        .loaden_hr  (loaden_hr),
        .loaden_min (loaden_min),
        .loaden_sec (loaden_sec),
        .run_en     (run_en),
        .mode       (mode),
        .edit_val   (edit_val)
    );

    // ---------------- scoreboard state ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] exp_q[$];          // {field(1=hr,2=min,3=sec), load}
    int         seen_cycles;
    logic [8:0] seen_val;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Strobe monitor: invariants every cycle, and capture of any strobe.
    always @(negedge clk) begin
        int sum;
        if (!reset) begin
            sum = int'(loaden_hr) + int'(loaden_min) + int'(loaden_sec);
            n_tests++;
            if (sum > 1 || (sum == 0 && load != 7'd0)) begin
                n_fail++;
                $display("FAIL strobe_invariant: loaden=%b%b%b load=%0d required onehot0 and load=0 when idle",
                         loaden_sec, loaden_min, loaden_hr, load);
            end
            if (sum > 0) begin
                seen_cycles++;
                seen_val = {(loaden_sec ? 2'd3 : (loaden_min ? 2'd2 : 2'd1)), load};
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);
    endtask

    // Press the selected buttons long enough to debounce, then release and settle.
    task automatic action(input logic m, input logic i);
        seen_cycles = 0;
        btn_mode = m;
        btn_inc  = i;
        step(D + 2);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step(D + 10);
    endtask

    task automatic check_after(input string tag, input int em, input int ee, input int er);
        logic [8:0] v;
        check({tag, "_mode"},   int'(mode),     em);
        check({tag, "_edit"},   int'(edit_val), ee);
        check({tag, "_run_en"}, int'(run_en),   er);
        if (exp_q.size() == 0) begin
            check({tag, "_no_strobe"}, seen_cycles, 0);
        end else begin
            v = exp_q.pop_front();
            check({tag, "_strobe_len"}, seen_cycles, 1);
            check({tag, "_strobe_val"}, int'(seen_val), int'(v));
        end
    endtask

    // ---------------- reference model ----------------
    int m_mode, m_edit;

    function automatic int fmax(input int md);
        return (md == 1) ? 23 : 59;
    endfunction

    task automatic model_step(input logic m, input logic i);
        if (m) begin
            if (m_mode != 0) exp_q.push_back({2'(m_mode), 7'(m_edit)});
            case (m_mode)
                0:       m_edit = int'(cur_hr);
                1:       m_edit = int'(cur_min);
                default: m_edit = 0;
            endcase
            m_mode = (m_mode + 1) % 4;
        end else if (i && m_mode != 0) begin
            m_edit = (m_edit >= fmax(m_mode)) ? 0 : m_edit + 1;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       m;
        logic       i;
        logic [1:0] exp_mode;
        logic [6:0] exp_edit;
        logic       exp_run;
        logic [1:0] exp_field;
        logic [6:0] exp_load;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic found;
        reset    = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cur_hr   = 7'd0;
        cur_min  = 7'd0;
        cur_sec  = 7'd0;

        // cur_hr=22, cur_min=59, cur_sec=7
        vecs[0]  = '{1'b1, 1'b0, 2'd1, 7'd22, 1'b0, 2'd0, 7'd0};
        vecs[1]  = '{1'b0, 1'b1, 2'd1, 7'd23, 1'b0, 2'd0, 7'd0};
        vecs[2]  = '{1'b0, 1'b1, 2'd1, 7'd0,  1'b0, 2'd0, 7'd0};
        vecs[3]  = '{1'b1, 1'b0, 2'd2, 7'd59, 1'b0, 2'd1, 7'd0};
        vecs[4]  = '{1'b0, 1'b1, 2'd2, 7'd0,  1'b0, 2'd0, 7'd0};
        vecs[5]  = '{1'b1, 1'b0, 2'd3, 7'd0,  1'b0, 2'd2, 7'd0};
        vecs[6]  = '{1'b0, 1'b1, 2'd3, 7'd1,  1'b0, 2'd0, 7'd0};
        vecs[7]  = '{1'b0, 1'b1, 2'd3, 7'd2,  1'b0, 2'd0, 7'd0};
        vecs[8]  = '{1'b1, 1'b0, 2'd0, 7'd0,  1'b1, 2'd3, 7'd2};
        vecs[9]  = '{1'b0, 1'b1, 2'd0, 7'd0,  1'b1, 2'd0, 7'd0};
        vecs[10] = '{1'b1, 1'b0, 2'd1, 7'd22, 1'b0, 2'd0, 7'd0};
        vecs[11] = '{1'b1, 1'b0, 2'd2, 7'd59, 1'b0, 2'd1, 7'd22};
        vecs[12] = '{1'b1, 1'b1, 2'd3, 7'd0,  1'b0, 2'd2, 7'd59};
        vecs[13] = '{1'b1, 1'b0, 2'd0, 7'd0,  1'b1, 2'd3, 7'd0};

        // Reset then idle.
        do_reset();
        step(100);
        check("idle_mode",   int'(mode),       0);
        check("idle_run_en", int'(run_en),     1);
        check("idle_ld_hr",  int'(loaden_hr),  0);
        check("idle_ld_min", int'(loaden_min), 0);
        check("idle_ld_sec", int'(loaden_sec), 0);
        check("idle_load",   int'(load),       0);
        check("idle_edit",   int'(edit_val),   0);

        // Table.
        cur_hr  = 7'd22;
        cur_min = 7'd59;
        cur_sec = 7'd7;
        for (int k = 0; k < 14; k++) begin
            if (vecs[k].exp_field != 2'd0) exp_q.push_back({vecs[k].exp_field, vecs[k].exp_load});
            action(vecs[k].m, vecs[k].i);
            check_after($sformatf("vec%0d", k), int'(vecs[k].exp_mode),
                        int'(vecs[k].exp_edit), int'(vecs[k].exp_run));
        end

        // Debounce glitch and exact latency.
        do_reset();
        cur_hr = 7'd5;
        action(1'b1, 1'b0);
        check("lat_enter_edit", int'(edit_val), 5);
        btn_inc = 1'b1;
        step(D - 1);
        btn_inc = 1'b0;
        step(D + 10);
        check("glitch_no_press", int'(edit_val), 5);
        btn_inc = 1'b1;
        step(D + 3);
        check("lat_before", int'(edit_val), 5);
        step(1);
        check("lat_at", int'(edit_val), 6);
        btn_inc = 1'b0;
        step(D + 10);

        // Reset in SET_HR discards the edit.
        do_reset();
        cur_hr = 7'd10;
        action(1'b1, 1'b0);
        action(1'b0, 1'b1);
        action(1'b0, 1'b1);
        action(1'b0, 1'b1);
        check("rst_pre_edit", int'(edit_val), 13);
        seen_cycles = 0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(D + 10);
        check("rst_no_strobe", seen_cycles, 0);
        check("rst_mode",      int'(mode),     0);
        check("rst_edit",      int'(edit_val), 0);
        check("rst_run_en",    int'(run_en),   1);

        // Button held through reset release.
        btn_mode = 1'b1;
        reset    = 1'b1;
        step(3);
        reset = 1'b0;
        step(D + 3);
        check("held_rst_before", int'(mode), 0);
        step(1);
        check("held_rst_at", int'(mode), 1);
        btn_mode = 1'b0;
        step(D + 10);

        // Long inc hold: repeats only when the feature is built in.
        do_reset();
        cur_hr = 7'd0;
        action(1'b1, 1'b0);
        btn_inc = 1'b1;
        found   = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            step(1);
            if (edit_val != 7'd0) found = 1'b1;
        end
        check("hold_first_press", int'(found), 1);
        check("hold_first_val", int'(edit_val), 1);
        step(111);
`ifdef CLOCK_SET_AUTOREPEAT_EN
        check("hold_rep_before", int'(edit_val), 4);
        step(1);
        check("hold_rep_at", int'(edit_val), 5);
`else
        check("hold_norep_a", int'(edit_val), 1);
        step(1);
        check("hold_norep_b", int'(edit_val), 1);
`endif
        btn_inc = 1'b0;
        step(D + 10);

        // Randomized actions against the model.
        do_reset();
        exp_q.delete();
        m_mode = 0;
        m_edit = 0;
        for (int k = 0; k < 60; k++) begin
            int   r;
            logic m, i;
            cur_hr  = 7'($urandom_range(0, 127));
            cur_min = 7'($urandom_range(0, 127));
            cur_sec = 7'($urandom_range(0, 127));
            r = int'($urandom_range(0, 99));
            m = (r < 50) || (r >= 85);
            i = (r >= 50);
            model_step(m, i);
            action(m, i);
            check_after($sformatf("rnd%0d", k), m_mode, m_edit, (m_mode == 0) ? 1 : 0);
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
